// File: rtl/cmp_share_if.sv
// Request/response bundle between four requesters, the shared comparator
// arbiter and the result consumer.
interface cmp_share_if #(
  parameter int N = 4
);
  logic [3:0]     req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [3:0]     req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic           rsp_gt;
  logic           rsp_eq;
  logic           rsp_lt;
  logic           rsp_ready;

  // Requesters and the result consumer drive this side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt
  );

  // The arbiter drives this side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// One unsigned N-bit magnitude comparator shared by four requesters through a
// round-robin grant and an IDLE -> COMPARE -> RESPOND sequence.
module cmp_share_arbiter #(
  parameter int N = 4
) (
  input logic        clk,
  input logic        rst_n,
  cmp_share_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t         state;
  logic [1:0]     last_grant;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           active;
  logic           rsp_valid_q;
  logic [1:0]     rsp_id_q;
  logic           rsp_gt_q;
  logic           rsp_eq_q;
  logic           rsp_lt_q;

  logic           pick_found;
  logic [1:0]     pick_idx;
  logic [1:0]     cand;
  logic           grant_fire;

  // Round-robin search: start one past the last winner and wrap upward.
  // NOTE: every variable assigned here gets a default before the loop so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant;
    cand       = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // active stays low until the first rising edge after reset release, so
  // nothing is granted in the release cycle itself.
  assign grant_fire    = active && (state == IDLE) && pick_found;
  assign bus.req_ready = grant_fire ? (4'b0001 << pick_idx) : 4'b0000;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_gt    = rsp_gt_q;
  assign bus.rsp_eq    = rsp_eq_q;
  assign bus.rsp_lt    = rsp_lt_q;

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too, so no stale data survives.
      state       <= IDLE;
      last_grant  <= 2'd3;
      op_a        <= '0;
      op_b        <= '0;
      active      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_gt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_lt_q    <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            op_a       <= bus.req_a[pick_idx*N +: N];
            op_b       <= bus.req_b[pick_idx*N +: N];
            rsp_id_q   <= pick_idx;
            last_grant <= pick_idx;
            state      <= COMPARE;
          end
        end
        COMPARE: begin
          rsp_gt_q    <= (op_a > op_b);
          rsp_eq_q    <= (op_a == op_b);
          rsp_lt_q    <= (op_a < op_b);
          rsp_valid_q <= 1'b1;
          state       <= RESPOND;
        end
        RESPOND: begin
          // Result fields are held until the consumer takes them.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed table, multi-cycle corner sequences
// and randomized traffic against a cycle-level transaction model.
module tb_cmp_share_arbiter;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cmp_share_if #(.N(N)) bus ();

  cmp_share_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the one outstanding transaction by its age in
  // cycles since grant, and picks winners by modular search from last grant.
  int m_last = 3;
  bit m_busy = 0;
  bit m_live = 0;
  int m_age  = 0;
  int m_id   = 0;
  int m_a    = 0;
  int m_b    = 0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("rst_ready", bus.req_ready, 0);
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_fields", {bus.rsp_id, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 0);
        m_last = 3; m_busy = 0; m_live = 0; m_age = 0;
      end else begin
        int       g;
        bit       exp_valid;
        logic [3:0] exp_ready;
        g         = -1;
        exp_ready = 4'b0000;
        exp_valid = m_busy && (m_age >= 2);
        if (m_live && !m_busy) begin
          for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (g < 0 && bus.req_valid[i]) g = i;
          end
          if (g >= 0) exp_ready = 4'b0001 << g;
        end
        check("mdl_ready", bus.req_ready, exp_ready);
        check("mdl_onehot0", $onehot0(bus.req_ready), 1);
        check("mdl_valid", bus.rsp_valid, exp_valid);
        if (exp_valid) begin
          check("mdl_id", bus.rsp_id, m_id);
          check("mdl_gel", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt},
                {m_a > m_b, m_a == m_b, m_a < m_b});
        end
        if (m_busy) begin
          if (m_age >= 2 && bus.rsp_ready) m_busy = 0;
          else m_age++;
        end else if (g >= 0) begin
          m_busy = 1;
          m_age  = 1;
          m_id   = g;
          m_a    = bus.req_a[g*N +: N];
          m_b    = bus.req_b[g*N +: N];
          m_last = g;
        end
        m_live = 1;
      end
    end
  end

  typedef struct {
    logic [3:0] mask;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] id;
    logic [2:0] gel;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[i*N +: N] = a;
    bus.req_b[i*N +: N] = b;
  endtask

  // Single-request transaction with rsp_ready high; checks grant and T+2 latency.
  task automatic run_txn(input vec_t v);
    int n;
    int idx;
    idx = 0;
    for (int i = 0; i < 4; i++) if (v.mask[i]) idx = i;
    @(negedge clk);
    bus.req_valid = v.mask;
    set_op(idx, v.a, v.b);
    bus.rsp_ready = 1'b1;
    #3;
    n = 0;
    while (bus.req_ready == 4'b0000 && n < 20) begin
      @(negedge clk); #3; n++;
    end
    check("vec_grant", bus.req_ready, v.mask);
    @(negedge clk);
    bus.req_valid = '0;
    #3 check("vec_t1_valid", bus.rsp_valid, 0);
    @(negedge clk);
    #3 check("vec_t2_valid", bus.rsp_valid, 1);
    check("vec_id", bus.rsp_id, v.id);
    check("vec_gel", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, v.gel);
  endtask

  initial begin
    int gi[8];
    int gc[8];
    int ng;

    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;

    vecs[0] = '{4'b0001, 4'd9,  4'd3,  2'd0, 3'b100};
    vecs[1] = '{4'b0100, 4'd0,  4'd15, 2'd2, 3'b001};
    vecs[2] = '{4'b1000, 4'd15, 4'd15, 2'd3, 3'b010};
    vecs[3] = '{4'b0010, 4'd0,  4'd0,  2'd1, 3'b010};
    vecs[4] = '{4'b0010, 4'd15, 4'd0,  2'd1, 3'b100};
    vecs[5] = '{4'b0001, 4'd7,  4'd8,  2'd0, 3'b001};
    vecs[6] = '{4'b1000, 4'd14, 4'd15, 2'd3, 3'b001};
    vecs[7] = '{4'b0100, 4'd8,  4'd7,  2'd2, 3'b100};

    // Reset state and release-cycle behaviour.
    @(negedge clk); #3;
    check("reset_valid", bus.rsp_valid, 0);
    do_reset();
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Four persistent requesters: order 0,1,2,3,0 every three cycles.
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, 4'd5, 4'd5);
    bus.rsp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      if (bus.req_ready != 0 && ng < 8) begin
        for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gi[ng] = i;
        gc[ng] = c;
        ng++;
      end
      if (bus.rsp_valid) check("rr_eq", bus.rsp_eq, 1);
    end
    check("rr_count", ng, 5);
    for (int k = 0; k < 5 && k < ng; k++) begin
      check("rr_order", gi[k], k % 4);
      check("rr_cycle", gc[k], 3 * k);
    end

    // Back-pressure: response held six cycles.
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0100; set_op(2, 4'd0, 4'd15); bus.rsp_ready = 1'b0;
    #3 check("bp_grant", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    #3 check("bp_t1_valid", bus.rsp_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_fields", {bus.rsp_id, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, {2'd2, 3'b001});
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #3 check("bp_last_valid", {bus.rsp_valid, bus.rsp_lt}, 2'b11);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #3 check("bp_idle_valid", bus.rsp_valid, 0);

    // Wrap-around: grant 3, then 0 wins over a later requester.
    @(negedge clk);
    bus.req_valid = 4'b1000; set_op(3, 4'd15, 4'd15);
    #3 check("wrap_grant3", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.req_valid = 4'b1001; set_op(0, 4'd1, 4'd2);
    #3 check("wrap_busy", bus.req_ready, 0);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #3 check("wrap_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_eq}, {1'b1, 2'd3, 1'b1});
    @(negedge clk);
    #3 check("wrap_grant0", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in RESPOND.
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0001; set_op(0, 4'd9, 4'd3); bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #3 check("arst_pre_valid", {bus.rsp_valid, bus.rsp_gt}, 2'b11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.rsp_valid, 0);
    check("arst_fields", {bus.rsp_id, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 0);
    check("arst_ready", bus.req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    bus.req_valid = 4'b0010; bus.rsp_ready = 1'b1;
    #2 check("arst_release_ready", bus.req_ready, 0);
    check("arst_release_valid", bus.rsp_valid, 0);
    @(negedge clk);
    #3 check("arst_grant1", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic; the model process does the checking.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.req_valid = 4'($urandom);
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.req_a = '0;
      if ($urandom_range(0, 7) == 0) bus.req_b = '1;
      if ($urandom_range(0, 9) == 0) bus.req_b = bus.req_a;
      bus.rsp_ready = 1'($urandom);
    end

    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_share_arbiter.md
CMP_SHARE_ARBITER -- requirements
Module: cmp_share_arbiter

Interface
REQ-001 Parameter N, default 4: operand width in bits, N >= 1.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  4  per-requester request strobe; bit i belongs to requester i.
REQ-005 req_a  input  4*N  requester i operand A in bits [i*N+N-1 : i*N].
REQ-006 req_b  input  4*N  requester i operand B in bits [i*N+N-1 : i*N].
REQ-007 req_ready  output  4  one-hot grant/accept pulse; at most one bit high per cycle.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_id  output  2  index of the requester that owns the result.
REQ-010 rsp_gt / rsp_eq / rsp_lt  output  1 each  registered unsigned A>B, A==B, A<B.
REQ-011 rsp_ready  input  1  consumer accepts the result.

Function
REQ-012 Block SHALL share one unsigned N-bit magnitude comparator among four requesters via a three-state FSM: IDLE, COMPARE, RESPOND.
REQ-013 IDLE: if any req_valid bit is set, SHALL select one by round-robin, drive that req_ready bit high for exactly that cycle, capture its A/B into operand registers and its index into rsp_id, and move to COMPARE; otherwise stay in IDLE.
REQ-014 A request is transferred only in a cycle where req_valid[i] and req_ready[i] are both high; req_ready SHALL be 0 in COMPARE and RESPOND.
REQ-015 Round-robin: priority search starts at index (last_grant+1) mod 4 and proceeds upward with wrap-around; after reset last_grant = 3, so requester 0 has top priority.
REQ-016 last_grant SHALL update only on a grant.
REQ-017 COMPARE: SHALL register the comparator outputs of the captured operands into rsp_gt/rsp_eq/rsp_lt, then go to RESPOND; this lasts exactly one cycle.
REQ-018 RESPOND: rsp_valid SHALL be 1 and rsp_id/rsp_gt/rsp_eq/rsp_lt SHALL be held stable until rsp_ready is sampled high.
REQ-019 rsp_ready high in RESPOND SHALL return the FSM to IDLE; rsp_valid SHALL be 0 in the following cycle.
REQ-020 Exactly one of rsp_gt/rsp_eq/rsp_lt SHALL be 1 whenever rsp_valid is 1.
REQ-021 Latency: grant at cycle T gives rsp_valid at T+2; with rsp_ready held high the next grant is at T+3 (one result per 3 cycles max).
REQ-022 rsp_ready outside RESPOND SHALL be ignored.
REQ-023 A requester that drops req_valid before being granted SHALL simply lose its turn; no state is kept for it.
REQ-024 Comparison is unsigned over the full N bits; operands 0 and 2^N-1 SHALL compare correctly.

Reset
REQ-025 rst_n low SHALL immediately, regardless of clk, force FSM=IDLE, last_grant=3, req_ready=0, rsp_valid=0, rsp_id=0, rsp_gt=0, rsp_eq=0, rsp_lt=0, operand registers=0.
REQ-026 Reset asserted during COMPARE or RESPOND SHALL discard the in-flight request with no response; first grant after release follows REQ-015.
REQ-027 Reset release SHALL take effect on the first clk rising edge with rst_n high; no grant in the release cycle itself.

Verification
REQ-028 N=4, reset then req_valid=0001, A0=9, B0=3, rsp_ready=1 -> req_ready=0001 at T, rsp_valid=1 at T+2 with rsp_id=0, gt=1, eq=0, lt=0.
REQ-029 All four req_valid held high, each A=B=5, rsp_ready=1 -> grant order 0,1,2,3,0 every 3 cycles, every response eq=1.
REQ-030 req_valid=0100, A2=0, B2=15, rsp_ready=0 for 5 cycles then 1 -> rsp_valid high 6 cycles, rsp_id=2, lt=1 stable throughout; IDLE next cycle.
REQ-031 Grant requester 3 (A=15, B=15) then assert rsp_ready with req_valid=1001 -> next grant is requester 0 (wrap-around), earlier response eq=1.
REQ-032 rst_n pulsed low mid-RESPOND -> outputs zero asynchronously; after release no stale rsp_valid; req_valid=0010 granted to 1.
REQ-033 Randomized requests with rsp_ready toggling -> scoreboard matches rsp_* to reference A>B/A==B/A<B per rsp_id, req_ready one-hot or zero every cycle.
